// File: rtl/cla_pipe_param_pkg.sv
// Shared types for the pipelined parallel-prefix adder: KGP carry-status encoding.
// Latency: none (types and a pure combinational helper only).
// Backpressure: not applicable.
package cla_pipe_pkg;

    // Carry status of a bit span: Kill, Propagate, Generate.
    typedef logic [1:0] kgp_t;

    localparam kgp_t KGP_K = 2'b00;
    localparam kgp_t KGP_P = 2'b01;
    localparam kgp_t KGP_G = 2'b11;

    // {a&b, a|b} lands directly on the encoding above: 00=K, 01=P, 11=G.
    function automatic kgp_t kgp_encode(input logic a, input logic b);
        return {a & b, a | b};
    endfunction

endpackage

// File: rtl/cla_pipe_param_if.sv
// Operand/result bundle for cla_pipe_param; ovf exists only with CLA_PIPE_OVF_EN.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; flush and busy ride along.
interface cla_pipe_param_if #(
    parameter int WIDTH = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             busy;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf;

    modport master (
        output flush, in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, busy, ovf
    );
    modport slave (
        input  flush, in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, busy, ovf
    );
`else
    modport master (
        output flush, in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, busy
    );
    modport slave (
        input  flush, in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, busy
    );
`endif
endinterface

// File: rtl/cla_pipe_param_kgp_merge.sv
// Two-input prefix combine: the upper span decides unless it only propagates.
// Latency: combinational.
// Backpressure: not applicable.
module kgp_merge
    import cla_pipe_pkg::*;
(
    input  kgp_t hi,
    input  kgp_t lo,
    output kgp_t o
);

    // K and G from the upper span are final; P defers to the lower span.
    always_comb begin
        o = hi;
        if (hi == KGP_P) begin
            o = lo;
        end
    end

endmodule

// File: rtl/cla_pipe_param.sv
// Pipelined Kogge-Stone adder/subtractor, WIDTH bits; CLA_PIPE_OVF_EN adds a signed-overflow output.
// Latency: LEVELS+1 cycles from accepting edge to sum/out_valid; one op per cycle.
// Backpressure: global stall, en = !out_valid || out_ready; flush drops every in-flight op.
module cla_pipe_param
    import cla_pipe_pkg::*;
#(
    parameter  int WIDTH  = 16,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_pipe_param_if.slave io
);

    logic en;
    assign en          = !io.out_valid || io.out_ready;
    assign io.in_ready = en;

    // ---------------- operand encode ----------------
    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] p_in;
    logic             c_in;
    kgp_t             cin_kgp;
    kgp_t [WIDTH-1:0] kgp_raw;
    kgp_t [WIDTH-1:0] kgp_in;

    // Subtraction is A + ~B + 1, so the carry-in is forced high in sub mode.
    always_comb begin
        bp      = io.sub ? ~io.b : io.b;
        c_in    = io.sub | io.cin;
        p_in    = io.a ^ bp;
        cin_kgp = c_in ? KGP_G : KGP_K;
        kgp_raw = '0;
        for (int i = 0; i < WIDTH; i++) begin
            kgp_raw[i] = kgp_encode(io.a[i], bp[i]);
        end
    end

    // Fold the carry-in (position -1, never P) into bit 0 up front, so WIDTH
    // positions and LEVELS levels are enough to resolve every carry.
    kgp_merge u_merge_cin (
        .hi (kgp_raw[0]),
        .lo (cin_kgp),
        .o  (kgp_in[0])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_in
        assign kgp_in[i] = kgp_raw[i];
    end

    // ---------------- pipeline state ----------------
    kgp_t [WIDTH-1:0] kgp_q   [LEVELS+1];
    kgp_t [WIDTH-1:0] kgp_nxt [LEVELS];
    logic [WIDTH-1:0] p_q     [LEVELS+1];
    logic [LEVELS:0]  c0_q;
    logic [LEVELS:0]  vld_q;
    logic             out_vld_q;
    logic [WIDTH:0]   sum_q;

    // Prefix level l: span 2^l, low positions already final pass through.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i < (1 << l)) begin : g_pass
                assign kgp_nxt[l][i] = kgp_q[l][i];
            end else begin : g_merge
                kgp_merge u_merge (
                    .hi (kgp_q[l][i]),
                    .lo (kgp_q[l][i-(1<<l)]),
                    .o  (kgp_nxt[l][i])
                );
            end
        end
    end

    // Valid bits: flush clears regardless of stall; otherwise advance on en, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            out_vld_q <= 1'b0;
        end else if (io.flush) begin
            vld_q     <= '0;
            out_vld_q <= 1'b0;
        end else if (en) begin
            vld_q     <= {vld_q[LEVELS-1:0], io.in_valid};
            out_vld_q <= vld_q[LEVELS];
        end
    end

    // Stage data moves on en only; contents of invalid slots are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= LEVELS; s++) begin
                kgp_q[s] <= '0;
                p_q[s]   <= '0;
            end
            c0_q <= '0;
        end else if (en) begin
            kgp_q[0] <= kgp_in;
            p_q[0]   <= p_in;
            for (int s = 1; s <= LEVELS; s++) begin
                kgp_q[s] <= kgp_nxt[s-1];
                p_q[s]   <= p_q[s-1];
            end
            c0_q <= {c0_q[LEVELS-1:0], c_in};
        end
    end

    // ---------------- result ----------------
    logic [WIDTH-1:0] carry;
    logic [WIDTH:0]   sum_nxt;

    // After the last level every position is resolved to K or G.
    always_comb begin
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i] = (kgp_q[LEVELS][i] == KGP_G);
        end
    end

    assign sum_nxt = {carry[WIDTH-1], p_q[LEVELS] ^ {carry[WIDTH-2:0], c0_q[LEVELS]}};

`ifdef CLA_PIPE_OVF_EN
    logic ovf_q;

    // Result register: captures only real results, so sum holds across bubbles and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (en && vld_q[LEVELS] && !io.flush) begin
            sum_q <= sum_nxt;
            ovf_q <= carry[WIDTH-1] ^ carry[WIDTH-2];
        end
    end

    assign io.ovf = ovf_q;
`else
    // Result register: captures only real results, so sum holds across bubbles and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en && vld_q[LEVELS] && !io.flush) begin
            sum_q <= sum_nxt;
        end
    end
`endif

    assign io.out_valid = out_vld_q;
    assign io.sum       = sum_q;
    assign io.busy      = (|vld_q) | out_vld_q;

endmodule
